reg_file_arbiter: RTL and testbench



---
 rtl/reg_arb_pkg.sv | 27 ++
 rtl/reg_file_arbiter_if.sv | 32 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/reg_file_arbiter.sv | 127 ++++++++++++
 tb/tb_reg_file_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-port register file arbiter.
package reg_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_e;

  // Requester indices: system controller command path and auxiliary master.
  localparam int NUM_PORTS = 2;
  localparam int PORT_CTRL = 0;
  localparam int PORT_AUX  = 1;

  // One-hot grant / per-port pulse vector.
  typedef logic [NUM_PORTS-1:0] gnt_oh_t;

  // Turn a port index into its one-hot pulse vector.
  function automatic gnt_oh_t port_oh(input logic idx);
    gnt_oh_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_file_arbiter_if.sv
// Requester-side bus of the register file arbiter. Both ports share one
// bundle; per-port fields are packed by port index.
interface reg_file_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) ();

  logic    [NUM_PORTS-1:0]            REQ;
  logic    [NUM_PORTS-1:0]            WR;
  logic    [NUM_PORTS-1:0]            LOCK;
  logic    [NUM_PORTS*ADDR_WIDTH-1:0] ADDR;
  logic    [NUM_PORTS*DATA_WIDTH-1:0] WDATA;
  gnt_oh_t                            GNT;
  logic    [DATA_WIDTH-1:0]           RDATA;
  gnt_oh_t                            RVALID;
  gnt_oh_t                            RERR;

  // Requesters drive the access, observe the response pulses.
  modport master (
    output REQ, WR, LOCK, ADDR, WDATA,
    input  GNT, RDATA, RVALID, RERR
  );

  // Arbiter samples the access, drives the response pulses.
  modport slave (
    input  REQ, WR, LOCK, ADDR, WDATA,
    output GNT, RDATA, RVALID, RERR
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Purely combinational: on a tie the port that
// was not granted last wins; a lone requester always wins.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output gnt_oh_t              gnt
);

  // Resolve a tie against the last-grant pointer, else pass the request.
  always_comb begin
    gnt = '0;
    if (req[PORT_CTRL] && req[PORT_AUX]) begin
      if (last == 1'(PORT_AUX)) gnt[PORT_CTRL] = 1'b1;
      else                      gnt[PORT_AUX]  = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares the single-ported register file between the controller command
// path and an auxiliary master. One access in flight at a time; reads wait
// for the register file qualifier up to RD_TIMEOUT cycles.
module reg_file_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  reg_file_arbiter_if.slave     bus,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] ISSUE   = ST_ISSUE;
  localparam logic [1:0] WAIT_RD = ST_WAIT_RD;

  logic [1:0]       state;
  logic             last_gnt;   // index of the most recently granted port
  logic             lock_vld;
  logic             lock_own;
  logic             own;        // port owning the access in flight
  logic             own_wr;
  logic [CNT_W-1:0] rd_cnt;     // cycles already spent in WAIT_RD

  logic                 lock_active;
  logic [NUM_PORTS-1:0] elig;
  gnt_oh_t              win;
  logic                 win_idx;

  // A lock only blocks the other port while its owner still holds LOCK;
  // once the owner lets go the other port competes in the same IDLE cycle.
  always_comb begin
    lock_active = lock_vld & bus.LOCK[lock_own];
    elig        = bus.REQ;
    if (lock_active) elig[!lock_own] = 1'b0;
    win_idx     = win[PORT_AUX];
  end

  rr_arb2 u_rr (
    .req  (elig),
    .last (last_gnt),
    .gnt  (win)
  );

  // Sequencer, lock/pointer bookkeeping and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_gnt   <= 1'(PORT_AUX);
      lock_vld   <= 1'b0;
      lock_own   <= 1'b0;
      own        <= 1'b0;
      own_wr     <= 1'b0;
      rd_cnt     <= '0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      Address    <= '0;
      WrData     <= '0;
      bus.GNT    <= '0;
      bus.RVALID <= '0;
      bus.RERR   <= '0;
      bus.RDATA  <= '0;
    end else begin
      // Strobes and response pulses last exactly one cycle.
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      bus.GNT    <= '0;
      bus.RVALID <= '0;
      bus.RERR   <= '0;

      case (state)
        IDLE: begin
          lock_vld <= lock_active;
          if (|win) begin
            state    <= ISSUE;
            bus.GNT  <= win;
            last_gnt <= win_idx;
            own      <= win_idx;
            own_wr   <= bus.WR[win_idx];
            WrEn     <= bus.WR[win_idx];
            RdEn     <= !bus.WR[win_idx];
            Address  <= bus.ADDR[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            WrData   <= bus.WDATA[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            // Only the lock owner can win while a lock is active, so the
            // winner's LOCK alone decides whether the lock survives.
            lock_vld <= bus.LOCK[win_idx];
            lock_own <= win_idx;
          end
        end

        ISSUE: begin
          rd_cnt <= '0;
          state  <= own_wr ? IDLE : WAIT_RD;
        end

        WAIT_RD: begin
          // Valid in the last allowed cycle still counts as a good read.
          if (RdData_Valid) begin
            bus.RDATA  <= RdData;
            bus.RVALID <= port_oh(own);
            state      <= IDLE;
          end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            bus.RDATA  <= '0;
            bus.RERR   <= port_oh(own);
            state      <= IDLE;
          end else if (rd_cnt != {CNT_W{1'b1}}) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: directed table, hand sequences for lock,
// round-robin and reset corners, then randomized traffic against a
// transaction-level model.
module tb_reg_file_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int T  = 4;
  localparam int NR = 1500;

  logic          CLK, RST;
  logic          WrEn, RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData, RdData;
  logic          RdData_Valid;

  reg_file_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_file_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(T)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc, n_chk, n_fail, pend, rsp_delay;
  logic spur;
  logic [DW-1:0] rf [16];
  logic [DW-1:0] m_rf [16];

  logic [1:0]    p_req, p_wr, p_lock;
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];

  typedef struct {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;
    logic [1:0]    e_gnt;
    int            e_lat;
    logic [1:0]    e_rv;
    logic [1:0]    e_re;
    logic [DW-1:0] e_rdata;
  } vec_t;
  vec_t tbl [9];

  logic [1:0]    e_gnt [NR+16];
  logic          e_wr  [NR+16];
  logic [AW-1:0] e_addr[NR+16];
  logic [DW-1:0] e_wd  [NR+16];
  logic [1:0]    e_rv  [NR+16];
  logic [1:0]    e_re  [NR+16];
  logic [DW-1:0] e_rd  [NR+16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.REQ   = p_req;
    bus.WR    = p_wr;
    bus.LOCK  = p_lock;
    bus.ADDR  = {p_addr[1], p_addr[0]};
    bus.WDATA = {p_wd[1], p_wd[0]};
  endtask

  // One clock; also acts as the register file: stores writes and answers a
  // read rsp_delay cycles after RdEn (0 = never).
  task automatic step();
    logic          cap_rd, cap_wr;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    cap_rd = RdEn;
    cap_wr = WrEn;
    cap_a  = Address;
    cap_d  = WrData;
    @(posedge CLK);
    #1;
    cyc++;
    RdData_Valid = 1'b0;
    if (cap_wr) rf[cap_a] = cap_d;
    if (cap_rd) pend = rsp_delay;
    if (pend == 1) begin
      RdData_Valid = 1'b1;
      RdData       = rf[Address];
    end
    if (pend > 0) pend--;
    if (spur) begin
      RdData_Valid = 1'b1;
      RdData       = 8'hEE;
      spur         = 1'b0;
    end
  endtask

  function automatic logic [27:0] all_outs();
    return {bus.GNT, bus.RVALID, bus.RERR, WrEn, RdEn, Address, WrData, bus.RDATA};
  endfunction

  int            g1, c4, c0, next_free, w, d, done;
  logic          g0_early, any_evt, m_last, m_lock_vld, m_lock_own, la, el0, el1;
  logic [1:0]    pg, ex;

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; pend = 0; rsp_delay = 1; spur = 1'b0;
    RdData = '0; RdData_Valid = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'(8'hA0 + i);
    p_req = '0; p_wr = '0; p_lock = '0;
    p_addr[0] = '0; p_addr[1] = '0; p_wd[0] = '0; p_wd[1] = '0;
    drive();

    tbl[0] = '{1'b0, 1'b1, 4'd3,  8'h5A, 0, 2'b01, 0, 2'b00, 2'b00, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 4'd2,  8'hC3, 0, 2'b10, 0, 2'b00, 2'b00, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 4'd2,  8'h00, 1, 2'b10, 3, 2'b10, 2'b00, 8'hC3};
    tbl[3] = '{1'b0, 1'b0, 4'd3,  8'h00, 4, 2'b01, 6, 2'b01, 2'b00, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 4'd3,  8'h00, 0, 2'b01, 6, 2'b00, 2'b01, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 4'd2,  8'h00, 5, 2'b10, 6, 2'b00, 2'b10, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 4'd2,  8'h00, 2, 2'b01, 4, 2'b01, 2'b00, 8'hC3};
    tbl[7] = '{1'b1, 1'b1, 4'd15, 8'h81, 0, 2'b10, 0, 2'b00, 2'b00, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 4'd15, 8'h00, 3, 2'b01, 5, 2'b01, 2'b00, 8'h81};

    // Reset values
    RST = 1'b1;
    step(); step();
    chk("rst_outs", 32'(all_outs()), 0);
    RST = 1'b0;
    step();

    // Continuous requests from both ports alternate, port 0 first
    p_req = 2'b11; p_wr = 2'b11;
    p_addr[0] = 4'd0; p_wd[0] = 8'h10; p_addr[1] = 4'd1; p_wd[1] = 8'h21;
    drive();
    for (int j = 1; j <= 8; j++) begin
      step();
      ex = (j % 2 == 1) ? (((j / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("alt_gnt", bus.GNT, ex);
    end
    p_req = '0; drive();
    step(); step();

    // Directed single transactions
    for (int i = 0; i < 9; i++) begin
      vec_t v;
      v = tbl[i];
      p_req = '0; p_lock = '0;
      p_req[v.port] = 1'b1; p_wr[v.port] = v.wr;
      p_addr[v.port] = v.addr; p_wd[v.port] = v.wdata;
      rsp_delay = v.dly;
      drive();
      step();
      chk("tbl_gnt",  bus.GNT, v.e_gnt);
      chk("tbl_wren", WrEn, v.wr);
      chk("tbl_rden", RdEn, !v.wr);
      chk("tbl_addr", Address, v.addr);
      if (v.wr) chk("tbl_wdata", WrData, v.wdata);
      step();
      p_req = '0; drive();
      if (!v.wr) begin
        for (int k = 2; k < v.e_lat; k++) begin
          chk("tbl_quiet", {bus.RVALID, bus.RERR}, 0);
          step();
        end
        chk("tbl_rvalid", bus.RVALID, v.e_rv);
        chk("tbl_rerr",   bus.RERR,   v.e_re);
        chk("tbl_rdata",  bus.RDATA,  v.e_rdata);
        step();
        chk("tbl_after",  {bus.RVALID, bus.RERR}, 0);
        chk("tbl_hold",   bus.RDATA, v.e_rdata);
      end
      step(); step();
    end

    // Lock: port 1 write + three reads under LOCK starve port 0
    p_req = 2'b11; p_wr = 2'b11; p_lock = 2'b10;
    p_addr[0] = 4'd6; p_wd[0] = 8'h11; p_addr[1] = 4'd5; p_wd[1] = 8'h77;
    rsp_delay = 1; drive();
    g1 = 0; c4 = -1; c0 = -1; g0_early = 1'b0; pg = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pg[1]) begin
        if (g1 < 4) p_wr[1] = 1'b0;
        else begin p_req[1] = 1'b0; p_lock[1] = 1'b0; end
      end
      if (pg[0]) p_req[0] = 1'b0;
      drive();
      if (bus.GNT[1]) begin g1++; if (g1 == 4) c4 = cyc; end
      if (bus.GNT[0] && c0 < 0) begin c0 = cyc; g0_early = (c4 < 0); end
      pg = bus.GNT;
    end
    chk("lock_aux_grants", g1, 4);
    chk("lock_ctrl_blocked", g0_early, 0);
    chk("lock_release_delay", c0 - c4, 3);

    // Stray RdData_Valid while idle is ignored
    spur = 1'b1;
    step(); step();
    chk("spur_evt", {bus.RVALID, bus.RERR}, 0);
    chk("spur_rdata", bus.RDATA, 8'h77);

    // Reset in WAIT_RD drops the read and the pointer
    p_req = 2'b01; p_wr = 2'b00; p_lock = '0; p_addr[0] = 4'd3; rsp_delay = 0;
    drive();
    step();
    chk("rw_gnt", bus.GNT, 2'b01);
    step();
    p_req = '0; drive();
    RST = 1'b1;
    step();
    chk("rw_outs", 32'(all_outs()), 0);
    RST = 1'b0; pend = 0;
    any_evt = 1'b0;
    for (int i = 0; i < T + 3; i++) begin
      step();
      any_evt |= (|bus.RVALID) | (|bus.RERR);
    end
    chk("rw_no_evt", any_evt, 0);
    p_req = 2'b11; p_wr = 2'b11; p_addr[0] = 4'd8; p_addr[1] = 4'd9;
    drive();
    step();
    chk("rw_tie_gnt", bus.GNT, 2'b01);
    step();
    p_req = '0; drive();
    step(); step(); step();

    // Randomized traffic against a transaction-level model
    RST = 1'b1; p_req = '0; p_lock = '0; drive();
    step();
    RST = 1'b0; pend = 0;
    for (int i = 0; i < NR + 16; i++) begin
      e_gnt[i] = '0; e_wr[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0;
      e_rv[i] = '0; e_re[i] = '0; e_rd[i] = '0;
    end
    for (int i = 0; i < 16; i++) m_rf[i] = rf[i];
    m_last = 1'b1; m_lock_vld = 1'b0; m_lock_own = 1'b0; next_free = 0;
    for (int k = 0; k < NR; k++) begin
      chk("rnd_gnt",    bus.GNT,    e_gnt[k]);
      chk("rnd_rvalid", bus.RVALID, e_rv[k]);
      chk("rnd_rerr",   bus.RERR,   e_re[k]);
      chk("rnd_wren",   WrEn, (e_gnt[k] != 0) && e_wr[k]);
      chk("rnd_rden",   RdEn, (e_gnt[k] != 0) && !e_wr[k]);
      if (e_gnt[k] != 0) chk("rnd_addr", Address, e_addr[k]);
      if (e_gnt[k] != 0 && e_wr[k]) chk("rnd_wdata", WrData, e_wd[k]);
      if (e_rv[k] != 0 || e_re[k] != 0) chk("rnd_rdata", bus.RDATA, e_rd[k]);

      for (int p = 0; p < 2; p++) begin
        if (k > 0 && e_gnt[k-1][p]) begin
          p_req[p] = 1'b0;
          if ($urandom_range(0, 1) == 0) p_lock[p] = 1'b0;
        end
        if (!p_req[p] && $urandom_range(0, 2) == 0) begin
          p_req[p]  = 1'b1;
          p_wr[p]   = 1'($urandom_range(0, 1));
          p_lock[p] = ($urandom_range(0, 3) == 0);
          p_addr[p] = 4'($urandom);
          p_wd[p]   = 8'($urandom);
        end
      end
      drive();

      if (k >= next_free) begin
        la  = m_lock_vld && p_lock[m_lock_own];
        el0 = p_req[0] && !(la && m_lock_own == 1'b1);
        el1 = p_req[1] && !(la && m_lock_own == 1'b0);
        if (el0 && el1) w = (m_last == 1'b1) ? 0 : 1;
        else if (el0)   w = 0;
        else if (el1)   w = 1;
        else            w = -1;
        if (w < 0) begin
          m_lock_vld = la;
        end else begin
          m_last = 1'(w); m_lock_vld = p_lock[w]; m_lock_own = 1'(w);
          e_gnt[k+1]  = 2'(1 << w);
          e_wr[k+1]   = p_wr[w];
          e_addr[k+1] = p_addr[w];
          e_wd[k+1]   = p_wd[w];
          if (p_wr[w]) begin
            m_rf[p_addr[w]] = p_wd[w];
            next_free = k + 2;
          end else begin
            d = $urandom_range(0, 5);
            rsp_delay = d;
            if (d >= 1 && d <= T) begin
              done = k + 2 + d;
              e_rv[done] = 2'(1 << w);
              e_rd[done] = m_rf[p_addr[w]];
            end else begin
              done = k + 2 + T;
              e_re[done] = 2'(1 << w);
              e_rd[done] = '0;
            end
            next_free = done;
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
